// File: rtl/color_blob_tracker.sv
// color_blob_tracker: per-slot colour capture, +/-tol box match, per-frame pixel count and bounding box.
// Build option DETECT_OVERLAY_EN paints matching pixels with the lowest matching slot's palette colour.
module color_blob_tracker #(
  parameter int N_SLOTS  = 4,
  parameter int CW       = 10,
  parameter int CNT_W    = 19,
  parameter int SAMPLE_X = 640,
  parameter int SAMPLE_Y = 512,
  parameter int MIN_PIX  = 64
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [CW-1:0]            Rin,
  input  logic [CW-1:0]            Gin,
  input  logic [CW-1:0]            Bin,
  input  logic [10:0]              X,
  input  logic [10:0]              Y,
  input  logic                     pix_valid,
  input  logic                     VGA_VS,
  input  logic                     cap_req,
  input  logic [2:0]               cap_slot,
  input  logic [CW-1:0]            tol,
  output logic [CW-1:0]            Rout,
  output logic [CW-1:0]            Gout,
  output logic [CW-1:0]            Bout,
  output logic [N_SLOTS-1:0]       match_vec,
  output logic [N_SLOTS-1:0]       enable,
  output logic                     frame_done,
  output logic [N_SLOTS*CNT_W-1:0] cnt_o,
  output logic [N_SLOTS*44-1:0]    bbox_o
);

  localparam logic [CW-1:0]    CMAX    = '1;
  localparam logic [CW-1:0]    CZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_VALID} slot_state_e;

  slot_state_e       state_q [N_SLOTS];
  slot_state_e       state_d [N_SLOTS];
  logic [3*CW-1:0]   ref_q   [N_SLOTS];  // {R,G,B}
  logic [3*CW-1:0]   ref_d   [N_SLOTS];
  logic [CNT_W-1:0]  cnt_q   [N_SLOTS];
  logic [CNT_W-1:0]  cnt_d   [N_SLOTS];
  logic [10:0]       xmin_q  [N_SLOTS];
  logic [10:0]       xmin_d  [N_SLOTS];
  logic [10:0]       xmax_q  [N_SLOTS];
  logic [10:0]       xmax_d  [N_SLOTS];
  logic [10:0]       ymin_q  [N_SLOTS];
  logic [10:0]       ymin_d  [N_SLOTS];
  logic [10:0]       ymax_q  [N_SLOTS];
  logic [10:0]       ymax_d  [N_SLOTS];
  logic              vs_q;
  logic              sample_pix;
  logic              frame_end;
  logic [N_SLOTS-1:0] hit;
  logic [CW-1:0]     pix_r_d;
  logic [CW-1:0]     pix_g_d;
  logic [CW-1:0]     pix_b_d;

  // Inclusive window, clamped to the channel range without wrapping.
  function automatic logic in_window(input logic [CW-1:0] v, input logic [CW-1:0] r,
                                     input logic [CW-1:0] t);
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    lo = (r <= t) ? CZERO : r - t;
    hi = (r >= CMAX - t) ? CMAX : r + t;
    return (v >= lo) && (v <= hi);
  endfunction

  assign sample_pix = pix_valid && (X == 11'(SAMPLE_X)) && (Y == 11'(SAMPLE_Y));
  assign frame_end  = !VGA_VS && vs_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      hit[i] = (state_q[i] == S_VALID) && pix_valid
            && in_window(Rin, ref_q[i][3*CW-1 -: CW], tol)
            && in_window(Gin, ref_q[i][2*CW-1 -: CW], tol)
            && in_window(Bin, ref_q[i][CW-1:0], tol);
    end
  end

  // Slot FSM: a new cap_req re-arms even a VALID slot; capture only happens from ARMED.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      state_d[i] = state_q[i];
      ref_d[i]   = ref_q[i];
      if (cap_req && (cap_slot == 3'(i))) begin
        state_d[i] = S_ARMED;
      end else if ((state_q[i] == S_ARMED) && sample_pix) begin
        state_d[i] = S_VALID;
        ref_d[i]   = {Rin, Gin, Bin};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      cnt_d[i]  = cnt_q[i];
      xmin_d[i] = xmin_q[i];
      xmax_d[i] = xmax_q[i];
      ymin_d[i] = ymin_q[i];
      ymax_d[i] = ymax_q[i];
      if (frame_end) begin
        cnt_d[i]  = '0;
        xmin_d[i] = '0;
        xmax_d[i] = '0;
        ymin_d[i] = '0;
        ymax_d[i] = '0;
      end
      // The edge-cycle pixel starts the new frame, so it sees the cleared accumulator.
      if (hit[i]) begin
        if (cnt_d[i] == '0) begin
          xmin_d[i] = X;
          xmax_d[i] = X;
          ymin_d[i] = Y;
          ymax_d[i] = Y;
        end else begin
          if (X < xmin_d[i]) xmin_d[i] = X;
          if (X > xmax_d[i]) xmax_d[i] = X;
          if (Y < ymin_d[i]) ymin_d[i] = Y;
          if (Y > ymax_d[i]) ymax_d[i] = Y;
        end
        if (cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + 1'b1;
      end
    end
  end

`ifdef DETECT_OVERLAY_EN
  always_comb begin
    {pix_r_d, pix_g_d, pix_b_d} = {Rin, Gin, Bin};
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        case (i)
          0:       {pix_r_d, pix_g_d, pix_b_d} = {CMAX, CZERO, CZERO};
          1:       {pix_r_d, pix_g_d, pix_b_d} = {CZERO, CMAX, CZERO};
          2:       {pix_r_d, pix_g_d, pix_b_d} = {CZERO, CZERO, CMAX};
          3:       {pix_r_d, pix_g_d, pix_b_d} = {CMAX, CMAX, CZERO};
          default: {pix_r_d, pix_g_d, pix_b_d} = {CMAX, CMAX, CMAX};
        endcase
      end
    end
  end
`else
  assign {pix_r_d, pix_g_d, pix_b_d} = {Rin, Gin, Bin};
`endif

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset) begin
      vs_q       <= 1'b0;
      Rout       <= '0;
      Gout       <= '0;
      Bout       <= '0;
      match_vec  <= '0;
      enable     <= '0;
      frame_done <= 1'b0;
      cnt_o      <= '0;
      bbox_o     <= '0;
      // NOTE: the reference arrays are small register files that must read 0 after reset, so they are reset too.
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        ref_q[i]   <= '0;
        cnt_q[i]   <= '0;
        xmin_q[i]  <= '0;
        xmax_q[i]  <= '0;
        ymin_q[i]  <= '0;
        ymax_q[i]  <= '0;
      end
    end else begin
      vs_q       <= VGA_VS;
      Rout       <= pix_r_d;
      Gout       <= pix_g_d;
      Bout       <= pix_b_d;
      match_vec  <= hit;
      frame_done <= frame_end;
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        ref_q[i]   <= ref_d[i];
        cnt_q[i]   <= cnt_d[i];
        xmin_q[i]  <= xmin_d[i];
        xmax_q[i]  <= xmax_d[i];
        ymin_q[i]  <= ymin_d[i];
        ymax_q[i]  <= ymax_d[i];
        if (frame_end) begin
          cnt_o[i*CNT_W +: CNT_W] <= cnt_q[i];
          bbox_o[i*44 +: 44]      <= (cnt_q[i] == '0) ? '0
                                   : {xmin_q[i], xmax_q[i], ymin_q[i], ymax_q[i]};
          enable[i]               <= (cnt_q[i] >= CNT_W'(MIN_PIX));
        end
      end
    end
  end

endmodule
